// File: rtl/urna_pkg.sv
// Shared types and vote-code decoding for the multi-candidate ballot box.
package urna_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2,
    CLOSED = 2'd3
  } state_t;

  localparam int unsigned BLANK_CODE = 0;

  // Tally layout: candidates 0..num_cand-1, then blank, then null.
  function automatic int unsigned vote_index(input int unsigned code,
                                             input int unsigned num_cand);
    if (code == BLANK_CODE) begin
      return num_cand;
    end else if (code <= num_cand) begin
      return code - 1;
    end else begin
      return num_cand + 1;
    end
  endfunction

endpackage

// File: rtl/urna_sat_counter.sv
// Saturating up-counter; sat flags that the count sits at its maximum.
module urna_sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             sat
);

  assign sat = &count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/urna_multi.sv
// Multi-candidate ballot box: voter-session FSM, saturating tallies, post-close readout.
// Optional winner/tie scan is built when URNA_WINNER_EN is defined.
module urna_multi
  import urna_pkg::*;
#(
  parameter int unsigned NUM_CAND = 4,
  parameter int unsigned CODE_W   = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned SEL_W    = $clog2(NUM_CAND + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              finish,
  input  logic              swap,
  input  logic              valid,
  input  logic [CODE_W-1:0] vote_code,
  output logic              vote_status,
  output logic [1:0]        estado,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  total_votes,
  output logic              overflow
`ifdef URNA_WINNER_EN
  ,
  output logic [SEL_W-1:0]  winner,
  output logic              tie
`endif
);

  localparam int unsigned NTALLY = NUM_CAND + 2;
  localparam int unsigned NCNT   = NUM_CAND + 3;

  state_t            state, next_state;
  logic              accept;
  int unsigned       vote_idx;
  logic [NCNT-1:0]   inc, sat;
  logic [CNT_W-1:0]  tally [NTALLY];

  // Session control; finish overrides every other transition.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE:    if (swap) next_state = ARMED;
      ARMED:   if (valid) begin
                 next_state = LOCKED;
                 accept     = 1'b1;
               end
      LOCKED:  if (swap) next_state = ARMED;
      default: ;
    endcase
    if (finish) next_state = CLOSED;
  end

  assign vote_idx = vote_index(32'(vote_code), NUM_CAND);

  for (genvar i = 0; i < NTALLY; i++) begin : g_tally
    assign inc[i] = accept && (vote_idx == i);
    urna_sat_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc[i]),
      .count (tally[i]),
      .sat   (sat[i])
    );
  end

  assign inc[NTALLY] = accept;
  urna_sat_counter #(.CNT_W(CNT_W)) u_total (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc[NTALLY]),
    .count (total_votes),
    .sat   (sat[NTALLY])
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      vote_status <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state       <= next_state;
      vote_status <= (next_state == LOCKED);
      overflow    <= overflow | (|(inc & sat));
    end
  end

  assign estado = state;

  // Tallies stay hidden until the poll is closed.
  always_comb begin
    rd_count = '0;
    if (state == CLOSED) begin
      for (int i = 0; i < NTALLY; i++) begin
        if (rd_sel == SEL_W'(i)) rd_count = tally[i];
      end
    end
  end

`ifdef URNA_WINNER_EN
  logic [SEL_W-1:0] scan_idx, best_idx;
  logic [CNT_W-1:0] best, cur;
  logic             best_tie;

  always_comb begin
    cur = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (scan_idx == SEL_W'(i)) cur = tally[i];
    end
  end

  // One candidate per cycle after close, then publish on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_idx <= '0;
      best_idx <= '0;
      best     <= '0;
      best_tie <= 1'b0;
      winner   <= '0;
      tie      <= 1'b0;
    end else if (state == CLOSED) begin
      if (scan_idx < SEL_W'(NUM_CAND)) begin
        if (scan_idx == '0 || cur > best) begin
          best     <= cur;
          best_idx <= scan_idx;
          best_tie <= 1'b0;
        end else if (cur == best) begin
          best_tie <= 1'b1;
        end
        scan_idx <= scan_idx + SEL_W'(1);
      end else if (scan_idx == SEL_W'(NUM_CAND)) begin
        winner   <= best_idx;
        tie      <= best_tie;
        scan_idx <= scan_idx + SEL_W'(1);
      end
    end
  end
`endif

endmodule
